// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } uart_rx_entry_t;

    localparam int unsigned ENTRY_W = $bits(uart_rx_entry_t);

    function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / (baud_rate * 16);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_v2.sv
// UART receiver: 16x oversampling, 2-of-3 majority sampling, optional parity, receive FIFO.
module uart_rx_v2
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rx_en,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("uart_rx_v2: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_v2: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_v2: STOP_BITS must be 1 or 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_rx_v2: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_v2: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic             sync1_q, sync2_q, rx_prev_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick, mid_tick, end_tick;
    rx_state_e        state_q, state_d;
    logic [3:0]       tick_idx_q, tick_idx_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       data_q, data_d;
    logic             par_err_q, par_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             maj, exp_par;
    logic             start_det, push;

    uart_rx_entry_t   push_entry, head;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // Restarting on the start edge aligns tick phase to the falling edge.
    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (start_det || tick) begin
            div_d = '0;
        end
    end

    assign mid_tick = tick && (tick_idx_q == 4'd9);
    assign end_tick = tick && (tick_idx_q == 4'd15);
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign exp_par  = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);

    always_comb begin
        state_d     = state_q;
        tick_idx_d  = tick_idx_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        samp_d      = samp_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        start_det   = 1'b0;
        push        = 1'b0;

        if (tick && state_q != StIdle && state_q != StBreak) begin
            tick_idx_d = tick_idx_q + 4'd1;
            if (tick_idx_q == 4'd7) samp_d[0] = rx_s;
            if (tick_idx_q == 4'd8) samp_d[1] = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_en && rx_prev_q && !rx_s) begin
                    start_det   = 1'b1;
                    state_d     = StStart;
                    tick_idx_d  = '0;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                    data_d      = '0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            StStart: begin
                if (mid_tick && maj) begin
                    state_d = StIdle;
                end else if (end_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mid_tick) begin
                    data_d[bit_idx_q] = maj;
                end
                if (end_tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (mid_tick) begin
                    par_err_d = (maj != exp_par);
                end
                if (end_tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (mid_tick) begin
                    frame_err_d = frame_err_q | ~maj;
                    // Leave at the mid-point of the last stop bit to absorb clock skew.
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = (frame_err_q | ~maj) ? StBreak : StIdle;
                    end
                end else if (end_tick) begin
                    stop_idx_d = 1'b1;
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rx_en) begin
            state_d = StIdle;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            state_q     <= StIdle;
            tick_idx_q  <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            samp_q      <= 2'b11;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            tick_idx_q  <= tick_idx_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign push_entry.frame_err  = frame_err_q | ~maj;
    assign push_entry.parity_err = par_err_q;
    assign push_entry.data       = data_q;

    // Set wins over clear; a push that coincides with a pop is never an overrun.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (push && fifo_full && !(rx_valid && rx_ready)) begin
            overrun_d = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (rx_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head          = fifo_rdata;
    assign rx_valid      = ~fifo_empty;
    assign rx_data       = rx_valid ? head.data : 8'h00;
    assign rx_parity_err = rx_valid & head.parity_err;
    assign rx_frame_err  = rx_valid & head.frame_err;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_v2.sv
// Randomised self-checking bench for uart_rx_v2: an 8N1 instance and a 7E2 instance.
module tb_uart_rx_v2;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD      = 25_000;
    localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD;
    localparam int unsigned TICK_CLKS = BIT_CLKS / 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b1;
    logic rx8 = 1'b1, rx7 = 1'b1;
    logic ready8 = 1'b0, ready7 = 1'b0;
    logic clr8 = 1'b0, clr7 = 1'b0;

    logic       valid8, pe8, fe8, ovr8;
    logic [7:0] data8;
    logic [4:0] cnt8;
    logic       valid7, pe7, fe7, ovr7;
    logic [7:0] data7;
    logic [2:0] cnt7;
    logic [9:0] head8, head7;

    int n_pass  = 0;
    int n_total = 0;
    logic [9:0] exp_q[$];

    assign head8 = {fe8, pe8, data8};
    assign head7 = {fe7, pe7, data7};

    always #5 clk = ~clk;

    uart_rx_v2 #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (16)
    ) u_dut8 (
        .clk (clk), .rst_n (rst_n), .rx (rx8), .rx_en (rx_en),
        .rx_valid (valid8), .rx_ready (ready8), .rx_data (data8),
        .rx_parity_err (pe8), .rx_frame_err (fe8), .rx_overrun (ovr8),
        .overrun_clr (clr8), .fifo_count (cnt8)
    );

    uart_rx_v2 #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .DATA_BITS (7),
        .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_dut7 (
        .clk (clk), .rst_n (rst_n), .rx (rx7), .rx_en (rx_en),
        .rx_valid (valid7), .rx_ready (ready7), .rx_data (data7),
        .rx_parity_err (pe7), .rx_frame_err (fe7), .rx_overrun (ovr7),
        .overrun_clr (clr7), .fifo_count (cnt7)
    );

    // Expected FIFO entry {frame_err, parity_err, data} for a frame as sent on the line.
    function automatic logic [9:0] model(input int which, input logic [7:0] d,
                                         input bit bad_par, input bit stop_zero);
        logic [7:0] m;
        logic       pe;
        m  = (which == 7) ? (d & 8'h7F) : d;
        pe = (which == 7) ? bad_par : 1'b0;
        return {stop_zero, pe, m};
    endfunction

    task automatic drive_bit(input int which, input logic v);
        if (which == 8) rx8 = v;
        else            rx7 = v;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit bad_par,
                              input bit stop_zero);
        int   nbits;
        int   nstop;
        logic par;
        nbits = (which == 8) ? 8 : 7;
        nstop = (which == 8) ? 1 : 2;
        drive_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
        if (which == 7) begin
            par = ^(d & 8'h7F);
            drive_bit(which, par ^ bad_par);
        end
        for (int s = 0; s < nstop; s++) drive_bit(which, ~stop_zero);
    endtask

    task automatic wait_valid(input int which);
        for (int i = 0; i < 2 * BIT_CLKS; i++) begin
            @(negedge clk);
            if ((which == 8 && valid8) || (which == 7 && valid7)) break;
        end
    endtask

    task automatic pop_one(input int which);
        @(negedge clk);
        if (which == 8) ready8 = 1'b1;
        else            ready7 = 1'b1;
        @(negedge clk);
        ready8 = 1'b0;
        ready7 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (valid8 !== 1'b0) $display("FAIL reset_valid8: got %b want 0", valid8); else n_pass++;
        n_total++; if (head8 !== 10'h0) $display("FAIL reset_head8: got %h want 000", head8); else n_pass++;
        n_total++; if (ovr8 !== 1'b0) $display("FAIL reset_ovr8: got %b want 0", ovr8); else n_pass++;
        n_total++; if (cnt8 !== 5'd0) $display("FAIL reset_cnt8: got %0d want 0", cnt8); else n_pass++;
        n_total++; if (valid7 !== 1'b0) $display("FAIL reset_valid7: got %b want 0", valid7); else n_pass++;
        n_total++; if (cnt7 !== 3'd0) $display("FAIL reset_cnt7: got %0d want 0", cnt7); else n_pass++;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic test_basic;
        send_frame(8, 8'h55, 1'b0, 1'b0);
        send_frame(8, 8'hA3, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd2) $display("FAIL basic_count: got %0d want 2", cnt8); else n_pass++;
        n_total++; if (head8 !== model(8, 8'h55, 0, 0))
            $display("FAIL basic_first: got %h want %h", head8, model(8, 8'h55, 0, 0)); else n_pass++;
        pop_one(8);
        n_total++; if (head8 !== model(8, 8'hA3, 0, 0))
            $display("FAIL basic_second: got %h want %h", head8, model(8, 8'hA3, 0, 0)); else n_pass++;
        pop_one(8);
        n_total++; if (valid8 !== 1'b0) $display("FAIL basic_empty: got %b want 0", valid8); else n_pass++;
    endtask

    task automatic test_parity;
        logic [7:0] d;
        send_frame(7, 8'h41, 1'b1, 1'b0);
        wait_valid(7);
        n_total++; if (head7 !== model(7, 8'h41, 1, 0))
            $display("FAIL parity_bad: got %h want %h", head7, model(7, 8'h41, 1, 0)); else n_pass++;
        pop_one(7);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send_frame(7, d, 1'b0, 1'b0);
            wait_valid(7);
            n_total++; if (head7 !== model(7, d, 0, 0))
                $display("FAIL parity_good: got %h want %h", head7, model(7, d, 0, 0)); else n_pass++;
            pop_one(7);
        end
        n_total++; if (valid7 !== 1'b0) $display("FAIL parity_empty: got %b want 0", valid7); else n_pass++;
    endtask

    task automatic test_break;
        logic [7:0] d;
        d = 8'($urandom);
        send_frame(8, d, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_bit(8, 1'b0);
        drive_bit(8, 1'b1);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd1) $display("FAIL break_count: got %0d want 1", cnt8); else n_pass++;
        n_total++; if (head8 !== model(8, d, 0, 1))
            $display("FAIL break_entry: got %h want %h", head8, model(8, d, 0, 1)); else n_pass++;
        pop_one(8);
        send_frame(8, 8'h0F, 1'b0, 1'b0);
        wait_valid(8);
        n_total++; if (head8 !== model(8, 8'h0F, 0, 0))
            $display("FAIL break_recover: got %h want %h", head8, model(8, 8'h0F, 0, 0)); else n_pass++;
        n_total++; if (cnt8 !== 5'd1) $display("FAIL break_recover_count: got %0d want 1", cnt8); else n_pass++;
        pop_one(8);
    endtask

    task automatic test_glitch;
        rx8 = 1'b0;
        repeat (4 * TICK_CLKS) @(posedge clk);
        rx8 = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd0) $display("FAIL glitch_count: got %0d want 0", cnt8); else n_pass++;
        send_frame(8, 8'h3C, 1'b0, 1'b0);
        wait_valid(8);
        n_total++; if (head8 !== model(8, 8'h3C, 0, 0))
            $display("FAIL glitch_next: got %h want %h", head8, model(8, 8'h3C, 0, 0)); else n_pass++;
        pop_one(8);
    endtask

    task automatic test_rx_en;
        rx_en = 1'b0;
        send_frame(8, 8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd0) $display("FAIL rx_en_off: got %0d want 0", cnt8); else n_pass++;
        rx_en = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 17; i++) send_frame(8, 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd16) $display("FAIL ovr_count: got %0d want 16", cnt8); else n_pass++;
        n_total++; if (ovr8 !== 1'b1) $display("FAIL ovr_set: got %b want 1", ovr8); else n_pass++;
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        @(negedge clk);
        n_total++; if (ovr8 !== 1'b0) $display("FAIL ovr_clear: got %b want 0", ovr8); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (head8 !== model(8, 8'(i), 0, 0))
                $display("FAIL ovr_order[%0d]: got %h want %h", i, head8, model(8, 8'(i), 0, 0));
            else n_pass++;
            pop_one(8);
        end
        n_total++; if (valid8 !== 1'b0) $display("FAIL ovr_drained: got %b want 0", valid8); else n_pass++;
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 3; i++) send_frame(8, 8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (cnt8 !== 5'd3) $display("FAIL mrst_queued: got %0d want 3", cnt8); else n_pass++;
        drive_bit(8, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(8, 1'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (valid8 !== 1'b0) $display("FAIL mrst_valid: got %b want 0", valid8); else n_pass++;
        n_total++; if (head8 !== 10'h0) $display("FAIL mrst_head: got %h want 000", head8); else n_pass++;
        n_total++; if (cnt8 !== 5'd0) $display("FAIL mrst_count: got %0d want 0", cnt8); else n_pass++;
        n_total++; if (ovr8 !== 1'b0) $display("FAIL mrst_ovr: got %b want 0", ovr8); else n_pass++;
        rx8 = 1'b1;
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        send_frame(8, 8'h7E, 1'b0, 1'b0);
        wait_valid(8);
        n_total++; if (head8 !== model(8, 8'h7E, 0, 0))
            $display("FAIL mrst_next: got %h want %h", head8, model(8, 8'h7E, 0, 0)); else n_pass++;
        n_total++; if (cnt8 !== 5'd1) $display("FAIL mrst_next_count: got %0d want 1", cnt8); else n_pass++;
        pop_one(8);
    endtask

    task automatic test_back_to_back;
        int n_frames;
        int got;
        n_frames = 24;
        got = 0;
        exp_q.delete();
        fork
            begin
                logic [7:0] d;
                for (int i = 0; i < n_frames; i++) begin
                    d = 8'($urandom);
                    exp_q.push_back(model(8, d, 0, 0));
                    send_frame(8, d, 1'b0, 1'b0);
                end
            end
            begin
                logic [9:0] e;
                for (int c = 0; c < n_frames * BIT_CLKS * 12 && got < n_frames; c++) begin
                    @(negedge clk);
                    ready8 = 1'($urandom_range(0, 1));
                    if (valid8 && ready8) begin
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
                        n_total++; if (head8 !== e)
                            $display("FAIL b2b_data[%0d]: got %h want %h", got, head8, e);
                        else n_pass++;
                        got++;
                    end
                end
            end
        join
        ready8 = 1'b0;
        n_total++; if (got !== n_frames) $display("FAIL b2b_total: got %0d want %0d", got, n_frames);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_rx_en();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
